// File: rtl/change_dispenser_if.sv
// Cashier-result / coin-mechanism bundle seen by change_dispenser.
// The master side (cashier plus coin mechanism) drives the i_* signals; the dispenser drives the o_* signals.
interface change_dispenser_if;
    logic        i_valid;
    logic        i_paid;
    logic [15:0] i_change;
    logic        i_coin_ready;
    logic        o_busy;
    logic        o_coin_valid;
    logic [2:0]  o_coin_sel;
    logic        o_done;
    logic [7:0]  o_coin_count;
    logic [15:0] o_residue;
    logic        o_drop;

    modport master (
        output i_valid, i_paid, i_change, i_coin_ready,
        input  o_busy, o_coin_valid, o_coin_sel, o_done, o_coin_count, o_residue, o_drop
    );

    modport slave (
        input  i_valid, i_paid, i_change, i_coin_ready,
        output o_busy, o_coin_valid, o_coin_sel, o_done, o_coin_count, o_residue, o_drop
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout of the cashier's change, one denomination tested per cycle; o_done 7 cycles after a zero-change accept.
// Backpressure: a presented coin holds until i_coin_ready; i_valid arriving while busy is dropped (o_drop).
module change_dispenser #(
    parameter logic [15:0] COIN0 = 16'd1000,
    parameter logic [15:0] COIN1 = 16'd500,
    parameter logic [15:0] COIN2 = 16'd100,
    parameter logic [15:0] COIN3 = 16'd50,
    parameter logic [15:0] COIN4 = 16'd10,
    parameter logic [15:0] COIN5 = 16'd1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    change_dispenser_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ISSUE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q,   idx_d;
    logic [15:0] rem_q,   rem_d;
    logic [7:0]  count_q, count_d;
    logic        drop_q,  drop_d;

    function automatic logic [15:0] coin_val(input logic [2:0] idx);
        case (idx)
            3'd0:    coin_val = COIN0;
            3'd1:    coin_val = COIN1;
            3'd2:    coin_val = COIN2;
            3'd3:    coin_val = COIN3;
            3'd4:    coin_val = COIN4;
            default: coin_val = COIN5;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        count_d = count_q;
        drop_d  = bus.i_valid && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    idx_d   = 3'd0;
                    count_d = 8'd0;
                    if (bus.i_paid) begin
                        rem_d   = bus.i_change;
                        state_d = S_SELECT;
                    end else begin
                        rem_d   = 16'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_SELECT: begin
                // idx only ever advances, so the payout is largest-first.
                if (coin_val(idx_q) <= rem_q) begin
                    state_d = S_ISSUE;
                end else if (idx_q == 3'd5) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_ISSUE: begin
                if (bus.i_coin_ready) begin
                    rem_d   = rem_q - coin_val(idx_q);
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    state_d = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            rem_q   <= 16'd0;
            count_q <= 8'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_coin_valid = (state_q == S_ISSUE);
    assign bus.o_coin_sel   = (state_q == S_ISSUE) ? idx_q : 3'd0;
    assign bus.o_done       = (state_q == S_DONE);
    assign bus.o_coin_count = count_q;
    assign bus.o_residue    = rem_q;
    assign bus.o_drop       = drop_q;

endmodule
